// File: rtl/acc_ctrl.sv
// Sequencing controller for the on-BRAM accumulator: accumulate, flush the write pipe, drain.
// Define ACC_CTRL_STATS_EN to add the stall_cycles / drain_stall_cycles counters.
module acc_ctrl #(
    parameter int unsigned LOG_MAX_ITERS          = 16,
    parameter int unsigned LOG_MAX_READS_PER_ITER = 16,
    parameter int unsigned ADD_LATENCY            = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic                              valid_in,
    output logic                              avail_out,
    input  logic                              avail_in,
    output logic                              valid_out,
    output logic                              rd_en,
    output logic [LOG_MAX_READS_PER_ITER-1:0] rd_addr,
    output logic                              wr_en,
    output logic [LOG_MAX_READS_PER_ITER-1:0] wr_addr,
    output logic                              acc_init,
    output logic                              busy,
    output logic                              done
`ifdef ACC_CTRL_STATS_EN
    ,
    output logic [31:0]                       stall_cycles,
    output logic [31:0]                       drain_stall_cycles
`endif
);

    localparam int unsigned IW   = LOG_MAX_ITERS;
    localparam int unsigned AW   = LOG_MAX_READS_PER_ITER;
    localparam int unsigned PIPE = 1 + ADD_LATENCY;

    typedef enum logic [1:0] {StIdle, StAccum, StFlush, StDrain} state_e;

    state_e          state_q;
    logic [IW-1:0]   iters_q;
    logic [IW-1:0]   iter_q;
    logic [AW-1:0]   reads_q;
    logic [AW-1:0]   addr_q;
    logic            valid_out_q;
    logic            done_q;
    logic [PIPE-1:0] wp_vld_q;
    logic [PIPE-1:0] wp_init_q;
    logic [AW-1:0]   wp_addr_q [PIPE];

    logic hazard;
    logic accept;
    logic drain_rd;
    logic addr_last;
    logic iter_last;
    logic pipe_empty;

    // A read of an address whose accumulated value is still in flight would return stale data.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(PIPE); i++) begin
            if (wp_vld_q[i] && (wp_addr_q[i] == addr_q)) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && (iter_q != '0);
    end

    assign avail_out  = (state_q == StAccum) && !hazard;
    assign accept     = avail_out && valid_in;
    assign drain_rd   = (state_q == StDrain) && avail_in;
    assign addr_last  = (addr_q == reads_q - AW'(1));
    assign iter_last  = (iter_q == iters_q - IW'(1));
    assign pipe_empty = (wp_vld_q == '0);

    assign rd_en     = accept || drain_rd;
    assign rd_addr   = addr_q;
    assign wr_en     = wp_vld_q[PIPE-1];
    assign wr_addr   = wp_addr_q[PIPE-1];
    assign acc_init  = wp_vld_q[PIPE-1] & wp_init_q[PIPE-1];
    assign busy      = (state_q != StIdle);
    assign valid_out = valid_out_q;
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            iters_q     <= '0;
            reads_q     <= '0;
            iter_q      <= '0;
            addr_q      <= '0;
            valid_out_q <= 1'b0;
            done_q      <= 1'b0;
            wp_vld_q    <= '0;
            wp_init_q   <= '0;
            for (int i = 0; i < int'(PIPE); i++) begin
                wp_addr_q[i] <= '0;
            end
        end else begin
            valid_out_q  <= drain_rd;
            done_q       <= 1'b0;
            wp_vld_q     <= {wp_vld_q[PIPE-2:0], accept};
            wp_init_q    <= {wp_init_q[PIPE-2:0], (iter_q == '0)};
            wp_addr_q[0] <= addr_q;
            for (int i = 1; i < int'(PIPE); i++) begin
                wp_addr_q[i] <= wp_addr_q[i-1];
            end

            case (state_q)
                StIdle: begin
                    if (configure) begin
                        iters_q <= num_iters;
                        reads_q <= num_reads_per_iter;
                        iter_q  <= '0;
                        addr_q  <= '0;
                        if ((num_iters == '0) || (num_reads_per_iter == '0)) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (accept) begin
                        if (addr_last) begin
                            addr_q <= '0;
                            if (iter_last) begin
                                state_q <= StFlush;
                            end else begin
                                iter_q <= iter_q + IW'(1);
                            end
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                StFlush: begin
                    if (pipe_empty) begin
                        addr_q  <= '0;
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_rd) begin
                        if (addr_last) begin
                            addr_q  <= '0;
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ACC_CTRL_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] drain_stall_q;

    always_ff @(posedge clk) begin
        if (rst || ((state_q == StIdle) && configure)) begin
            stall_q       <= '0;
            drain_stall_q <= '0;
        end else begin
            if ((state_q == StAccum) && valid_in && !avail_out && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if ((state_q == StDrain) && !avail_in && (drain_stall_q != '1)) begin
                drain_stall_q <= drain_stall_q + 32'd1;
            end
        end
    end

    assign stall_cycles       = stall_q;
    assign drain_stall_cycles = drain_stall_q;
`endif

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: job table plus reset-abort sequence, scoreboarded writes/drains.
module tb_acc_ctrl;

    localparam int unsigned IW      = 16;
    localparam int unsigned AW      = 16;
    localparam int unsigned ADD_LAT = 1;
    localparam int unsigned WR_DLY  = 1 + ADD_LAT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          configure = 1'b0;
    logic [IW-1:0] num_iters = '0;
    logic [AW-1:0] num_reads = '0;
    logic          valid_in = 1'b0;
    logic          avail_in = 1'b1;
    logic          avail_out, valid_out, rd_en, wr_en, acc_init, busy, done;
    logic [AW-1:0] rd_addr, wr_addr;
`ifdef ACC_CTRL_STATS_EN
    logic [31:0]   stall_cycles, drain_stall_cycles;
`endif

    acc_ctrl #(
        .LOG_MAX_ITERS          (IW),
        .LOG_MAX_READS_PER_ITER (AW),
        .ADD_LATENCY            (ADD_LAT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .configure          (configure),
        .num_iters          (num_iters),
        .num_reads_per_iter (num_reads),
        .valid_in           (valid_in),
        .avail_out          (avail_out),
        .avail_in           (avail_in),
        .valid_out          (valid_out),
        .rd_en              (rd_en),
        .rd_addr            (rd_addr),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .acc_init           (acc_init),
        .busy               (busy),
        .done               (done)
`ifdef ACC_CTRL_STATS_EN
        ,
        .stall_cycles       (stall_cycles),
        .drain_stall_cycles (drain_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          init;
    } wr_exp_t;

    wr_exp_t       wq[$];
    logic [AW-1:0] dq[$];

    typedef struct {
        int       iters;
        int       reads;
        int       pat_len;
        bit [7:0] pat;
        int       exp_stalls;
    } job_t;

    localparam int NJ = 7;
    job_t jobs[NJ];

    // Monitor: write timing/content and drain read/valid_out pairing, sampled on the falling edge.
    int              cyc = 0;
    int              done_cnt = 0;
    int              done_cyc = -10;
    int              last_drd_cyc = -10;
    bit [WR_DLY-1:0] acc_hist = '0;
    bit              drd_prev = 1'b0;
    bit              drd;
    wr_exp_t         mon_e;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            acc_hist = '0;
            drd_prev = 1'b0;
        end else begin
            if (wr_en || acc_hist[WR_DLY-1]) chk("wr_timing", wr_en, acc_hist[WR_DLY-1]);
            if (wr_en) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    mon_e = wq.pop_front();
                    chk("wr_addr", wr_addr, mon_e.addr);
                    chk("acc_init", acc_init, mon_e.init);
                end
            end
            drd = rd_en && !avail_out && busy;
            if (valid_out || drd_prev) chk("valid_out", valid_out, drd_prev);
            if (drd) begin
                if (dq.size() == 0) chk("drain_unexpected", 1, 0);
                else chk("drain_addr", rd_addr, dq.pop_front());
                last_drd_cyc = cyc;
                if (wr_en) chk("rd_wr_overlap", 1, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_not_busy", busy, 0);
            end
            acc_hist = {acc_hist[WR_DLY-2:0], (valid_in && avail_out)};
            drd_prev = drd;
        end
    end

    task automatic run_job(input int iters, input int reads, input int pat_len,
                           input bit [7:0] pat, input int exp_stalls);
        int stalls, to, base, zeros;
        bit ok;
        stalls = 0;
        zeros  = 0;
        ok     = 1'b1;
        base   = done_cnt;
        @(posedge clk); #1;
        configure = 1'b1;
        num_iters = IW'(iters);
        num_reads = AW'(reads);
        if (iters != 0 && reads != 0) begin
            for (int i = 0; i < iters; i++)
                for (int a = 0; a < reads; a++) wq.push_back('{addr: AW'(a), init: (i == 0)});
            for (int a = 0; a < reads; a++) dq.push_back(AW'(a));
        end
        @(posedge clk); #1;
        configure = 1'b0;
        if (iters == 0 || reads == 0) begin
            @(negedge clk);
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("zero_quiet", {busy, rd_en, wr_en, done}, 0);
            end
            return;
        end
        valid_in = 1'b1;
        @(negedge clk);
        chk("job_busy", busy, 1);
        for (int w = 0; w < iters * reads && ok; w++) begin
            to = 0;
            while (!avail_out && ok) begin
                stalls++;
                to++;
                if (to > 64) begin
                    chk("accept_timeout", 1, 0);
                    ok = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end
            if (ok) begin
                chk("accept_rd_en", rd_en, 1);
                chk("accept_rd_addr", rd_addr, w % reads);
                @(posedge clk); #1;
                if (w == iters * reads - 1) valid_in = 1'b0;
                @(negedge clk);
            end
        end
        valid_in = 1'b0;
        if (!ok) return;
        chk("stall_count", stalls, exp_stalls);
        to = 0;
        while (!(rd_en && !avail_out) && to < 64) begin
            to++;
            @(negedge clk);
        end
        if (to >= 64) begin
            chk("drain_timeout", 1, 0);
            return;
        end
        for (int p = 1; p < pat_len; p++) begin
            @(posedge clk); #1;
            avail_in = pat[p];
            if (!pat[p]) zeros++;
            @(negedge clk);
            chk("drain_rd_en", rd_en, pat[p]);
        end
        @(posedge clk); #1;
        avail_in = 1'b1;
        to = 0;
        while (done_cnt == base && to < 64) begin
            @(posedge clk);
            to++;
        end
        chk("done_seen", done_cnt, base + 1);
        chk("done_latency", done_cyc, last_drd_cyc + 1);
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
`ifdef ACC_CTRL_STATS_EN
        chk("stat_stalls", stall_cycles, exp_stalls);
        chk("stat_drain_stalls", drain_stall_cycles, zeros);
`endif
    endtask

    initial begin
        int base;
        jobs[0] = '{2, 4, 1, 8'h01, 0};          // basic job
        jobs[1] = '{3, 1, 1, 8'h01, 4};          // read-after-write hazard
        jobs[2] = '{0, 5, 1, 8'h01, 0};          // zero iterations
        jobs[3] = '{1, 3, 5, 8'b0001_1001, 0};   // drain backpressure 1,0,0,1,1
        jobs[4] = '{2, 2, 1, 8'h01, 1};
        jobs[5] = '{2, 3, 1, 8'h01, 0};
        jobs[6] = '{5, 0, 1, 8'h01, 0};          // zero reads

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {busy, done, valid_out, avail_out, rd_en, wr_en, acc_init}, 0);
        chk("rst_addrs", {rd_addr, wr_addr}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int j = 0; j < NJ; j++)
            run_job(jobs[j].iters, jobs[j].reads, jobs[j].pat_len, jobs[j].pat,
                    jobs[j].exp_stalls);

        // Reset after 3 of 8 words: job aborts silently, then a fresh job completes.
        base = done_cnt;
        @(posedge clk); #1;
        configure = 1'b1;
        num_iters = IW'(2);
        num_reads = AW'(4);
        for (int a = 0; a < 3; a++) wq.push_back('{addr: AW'(a), init: 1'b1});
        @(posedge clk); #1;
        configure = 1'b0;
        valid_in  = 1'b1;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk("abort_avail", avail_out, 1);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_flags", {busy, done, valid_out, avail_out, rd_en, wr_en, acc_init}, 0);
        chk("abort_addrs", {rd_addr, wr_addr}, 0);
        wq.delete();
        dq.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_idle", {busy, wr_en, rd_en}, 0);
        end
        chk("abort_no_done", done_cnt, base);
`ifdef ACC_CTRL_STATS_EN
        chk("abort_stats", {stall_cycles, drain_stall_cycles}, 0);
`endif
        run_job(1, 2, 1, 8'h01, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/acc_ctrl.md
Name: acc_ctrl

Overview:
- Sequencing controller for the on-BRAM accumulator datapath.
- Latches a job (num_iters × num_reads_per_iter) and accepts input words through a valid/avail handshake.
- Drives BRAM read/write addresses and enables, plus the init-vs-add select for the accumulator adder.
- After the last iteration, drains the accumulated words to the output interface and pulses done.

Parameters:
- LOG_MAX_ITERS, 16, width of the iteration count register.
- LOG_MAX_READS_PER_ITER, 16, width of the reads-per-iteration count and the BRAM address.
- ADD_LATENCY, 1, adder pipeline stages between BRAM read data and write-back (range 1..3).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- configure  in  1  job start strobe; accepted only in IDLE.
- num_iters  in  LOG_MAX_ITERS  iterations per job.
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  words (BRAM entries) per iteration.
- valid_in  in  1  upstream word valid.
- avail_out  out  1  controller can accept a word this cycle.
- avail_in  in  1  downstream can take the word issued this cycle.
- valid_out  out  1  drained word is present on the datapath output.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  LOG_MAX_READS_PER_ITER  BRAM read address.
- wr_en  out  1  BRAM write enable.
- wr_addr  out  LOG_MAX_READS_PER_ITER  BRAM write address.
- acc_init  out  1  aligned with wr_en: 1 = write the input word, 0 = write BRAM word + input word.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters and write pipeline cleared. Reset mid-job aborts the job with no done pulse.
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- States: IDLE, ACCUM, FLUSH, DRAIN.
- IDLE, configure=1:
  - Latch both counts, clear addr/iter counters.
  - If either count is 0: done=1 next cycle, stay IDLE.
  - Otherwise go to ACCUM.
- ACCUM:
  - A word is accepted when valid_in & avail_out.
  - On acceptance: rd_en=1, rd_addr=addr (the read is a don't-care when iter==0).
  - Write-back is delayed exactly 1+ADD_LATENCY cycles after acceptance, with wr_en=1, wr_addr=that addr, acc_init=(iter==0).
  - addr increments per accepted word; at num_reads_per_iter-1 it wraps to 0 and iter increments.
  - Accepting the word at iter=num_iters-1, addr=num_reads_per_iter-1 moves the FSM to FLUSH.
- Hazard rule:
  - avail_out=0 whenever the next addr equals any write address still pending in the write pipeline and iter>0.
  - This only fires when num_reads_per_iter ≤ 1+ADD_LATENCY.
  - Otherwise avail_out=1 throughout ACCUM.
- FLUSH: avail_out=0; wait until the write pipeline is empty, then go to DRAIN with addr=0.
- DRAIN:
  - When avail_in=1: rd_en=1, rd_addr=addr, addr increments.
  - valid_out=1 exactly one cycle after each issued read (BRAM read latency 1).
  - avail_in=0 issues nothing; it never revokes a read already issued.
  - After the read at addr=num_reads_per_iter-1 is issued, go to IDLE in the cycle its valid_out is asserted, with done=1 in that same cycle.
- configure outside IDLE is ignored.
- wr_en and rd_en are never both active in DRAIN.

Optional Feature:
- Macro: ACC_CTRL_STATS_EN.
- When defined:
  - Adds output stall_cycles[31:0]: counts ACCUM cycles with valid_in=1 & avail_out=0.
  - Adds output drain_stall_cycles[31:0]: counts DRAIN cycles with avail_in=0.
  - Both clear on rst and on an accepted configure; both saturate at all-ones.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Basic job: configure iters=2, reads=4, ADD_LATENCY=1, valid_in and avail_in held 1.
  - 8 words accepted with no stalls.
  - First 4 writes have acc_init=1, next 4 have acc_init=0.
  - 4 valid_out pulses at addr 0..3.
  - done asserted 1 cycle after the last drain read.
- Hazard: iters=3, reads=1, ADD_LATENCY=1, valid_in=1.
  - avail_out low 2 cycles between accepts in iterations 1 and 2.
  - Writes all target addr 0; 3 accepts total; 1 drained word.
- Zero config: configure with iters=0, reads=5.
  - done pulses next cycle.
  - busy, rd_en, wr_en stay 0.
- Backpressure in drain: iters=1, reads=3, avail_in pattern 1,0,0,1,1.
  - Reads issued only on avail_in=1 cycles (addr 0,1,2).
  - valid_out one cycle after each read.
- Reset mid-ACCUM: assert rst after 3 of 8 words.
  - Outputs 0 next cycle, no done pulse.
  - A new configure (iters=1, reads=2) completes normally.
- ACC_CTRL_STATS_EN: basic job with valid_in toggled by the hazard case.
  - stall_cycles equals the count of observed valid_in & !avail_out ACCUM cycles (4 in the hazard scenario).
